// File: rtl/viterbi_link_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_link_ctrl
// Frame sequencer for the Viterbi encoder/decoder link. It pulls payload bits
// from a source and feeds them to the encoder, then appends zero tail bits.
// It schedules single-bit error injection on the encoded symbol and checks the
// decoder output against a delayed copy of what was encoded.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start_i           : frame request, accepted only while idle
//   frame_len_i       : payload bit count (latched on accepted start, 0 legal)
//   err_period_i      : inject one error every N symbols, 0 disables
//   data_req_o        : combinational, high while payload is being pulled
//   data_i            : payload bit, sampled when data_req_o is high
//   encoder_i_o       : registered encoder data
//   enable_encoder_o  : registered encoder enable
//   err_inj_o         : XOR mask for the encoded symbol (2'b10 on injection)
//   decoder_i         : decoded bit returned by the decoder
//   busy_o            : frame in progress
//   done_o            : one-cycle completion pulse
//   bit_err_ct_o      : decoded-bit mismatches in the last frame (saturating)
//   inj_ct_o          : injected symbol errors in the last frame (saturating)
// -----------------------------------------------------------------------------
module viterbi_link_ctrl #(
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned TAIL    = 2,
    parameter int unsigned DEC_LAT = 8,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_len_i,
    input  logic [ERR_W-1:0]   err_period_i,
    output logic               data_req_o,
    input  logic               data_i,
    output logic               encoder_i_o,
    output logic               enable_encoder_o,
    output logic [1:0]         err_inj_o,
    input  logic               decoder_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [FRAME_W-1:0] bit_err_ct_o,
    output logic [FRAME_W-1:0] inj_ct_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_len;
    logic [ERR_W-1:0]   r_period;
    logic [FRAME_W-1:0] r_cnt;
    logic [ERR_W-1:0]   r_sym;
    logic               r_enc_cmp;

    // Reference delay line: occupied / compare-tag / bit per stage
    logic [DEC_LAT-1:0] r_dl_occ;
    logic [DEC_LAT-1:0] r_dl_cmp;
    logic [DEC_LAT-1:0] r_dl_bit;

    logic [DEC_LAT-1:0] w_dl_occ_nxt;
    logic [DEC_LAT-1:0] w_dl_cmp_nxt;
    logic [DEC_LAT-1:0] w_dl_bit_nxt;
    logic [ERR_W-1:0]   w_sym_nxt;
    logic               w_bit_err;
    logic               w_dl_empty;
    logic               w_last_send;
    logic               w_last_tail;

    assign data_req_o = (r_state == S_SEND);

    // The encoder output register is the entry point of the delay line, so an
    // entry reaches the last stage exactly when its decoded bit arrives.
    generate
        if (DEC_LAT > 1) begin : g_dl_multi
            assign w_dl_occ_nxt = {r_dl_occ[DEC_LAT-2:0], enable_encoder_o};
            assign w_dl_cmp_nxt = {r_dl_cmp[DEC_LAT-2:0], r_enc_cmp};
            assign w_dl_bit_nxt = {r_dl_bit[DEC_LAT-2:0], encoder_i_o};
        end else begin : g_dl_single
            assign w_dl_occ_nxt = enable_encoder_o;
            assign w_dl_cmp_nxt = r_enc_cmp;
            assign w_dl_bit_nxt = encoder_i_o;
        end
    endgenerate

    assign w_bit_err   = r_dl_occ[DEC_LAT-1] && r_dl_cmp[DEC_LAT-1] &&
                         (r_dl_bit[DEC_LAT-1] != decoder_i);
    // Drain finishes when every encoded symbol, tail included, has been retired
    assign w_dl_empty  = !enable_encoder_o && (r_dl_occ == '0);
    assign w_sym_nxt   = r_sym + ERR_W'(1);
    assign w_last_send = (r_cnt == r_len - FRAME_W'(1));
    assign w_last_tail = (r_cnt == FRAME_W'(TAIL - 1));

    // Sequencer, delay line, injection scheduler and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_len            <= '0;
            r_period         <= '0;
            r_cnt            <= '0;
            r_sym            <= '0;
            r_enc_cmp        <= 1'b0;
            r_dl_occ         <= '0;
            r_dl_cmp         <= '0;
            r_dl_bit         <= '0;
            encoder_i_o      <= 1'b0;
            enable_encoder_o <= 1'b0;
            err_inj_o        <= 2'b00;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            bit_err_ct_o     <= '0;
            inj_ct_o         <= '0;
        end else begin
            encoder_i_o      <= 1'b0;
            enable_encoder_o <= 1'b0;
            r_enc_cmp        <= 1'b0;
            err_inj_o        <= 2'b00;
            done_o           <= 1'b0;

            r_dl_occ <= w_dl_occ_nxt;
            r_dl_cmp <= w_dl_cmp_nxt;
            r_dl_bit <= w_dl_bit_nxt;

            if (w_bit_err && (bit_err_ct_o != '1)) begin
                bit_err_ct_o <= bit_err_ct_o + FRAME_W'(1);
            end

            // Count symbols presented to the encoder; flag the one after the Nth
            if (enable_encoder_o && (r_period != '0)) begin
                if (w_sym_nxt == r_period) begin
                    r_sym     <= '0;
                    err_inj_o <= 2'b10;
                    if (inj_ct_o != '1) begin
                        inj_ct_o <= inj_ct_o + FRAME_W'(1);
                    end
                end else begin
                    r_sym <= w_sym_nxt;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_len        <= frame_len_i;
                        r_period     <= err_period_i;
                        r_cnt        <= '0;
                        r_sym        <= '0;
                        bit_err_ct_o <= '0;
                        inj_ct_o     <= '0;
                        busy_o       <= 1'b1;
                        r_state      <= (frame_len_i == '0) ? S_TAIL : S_SEND;
                    end
                end
                S_SEND: begin
                    encoder_i_o      <= data_i;
                    enable_encoder_o <= 1'b1;
                    r_enc_cmp        <= 1'b1;
                    if (w_last_send) begin
                        r_cnt   <= '0;
                        r_state <= S_TAIL;
                    end else begin
                        r_cnt <= r_cnt + FRAME_W'(1);
                    end
                end
                S_TAIL: begin
                    enable_encoder_o <= 1'b1;
                    if (w_last_tail) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + FRAME_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_dl_empty) begin
                        done_o  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viterbi_link_ctrl
// Self-checking bench for viterbi_link_ctrl. Each frame is described by its
// length, injection period and a set of decoded-bit flips; expected per-cycle
// outputs and the end-of-frame report are derived from those numbers alone.
// -----------------------------------------------------------------------------
module tb_viterbi_link_ctrl;

    localparam int FRAME_W = 8;
    localparam int TAIL    = 2;
    localparam int DEC_LAT = 8;
    localparam int ERR_W   = 8;
    localparam int N       = 4096;
    localparam int SAT     = 255;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic [FRAME_W-1:0] frame_len_i;
    logic [ERR_W-1:0]   err_period_i;
    logic               data_req_o;
    logic               data_i;
    logic               encoder_i_o;
    logic               enable_encoder_o;
    logic [1:0]         err_inj_o;
    logic               decoder_i;
    logic               busy_o;
    logic               done_o;
    logic [FRAME_W-1:0] bit_err_ct_o;
    logic [FRAME_W-1:0] inj_ct_o;

    viterbi_link_ctrl #(
        .FRAME_W (FRAME_W),
        .TAIL    (TAIL),
        .DEC_LAT (DEC_LAT),
        .ERR_W   (ERR_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .frame_len_i      (frame_len_i),
        .err_period_i     (err_period_i),
        .data_req_o       (data_req_o),
        .data_i           (data_i),
        .encoder_i_o      (encoder_i_o),
        .enable_encoder_o (enable_encoder_o),
        .err_inj_o        (err_inj_o),
        .decoder_i        (decoder_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .bit_err_ct_o     (bit_err_ct_o),
        .inj_ct_o         (inj_ct_o)
    );

    typedef struct {
        int done_cyc;
        int errs;
        int injs;
    } frame_exp_t;

    frame_exp_t sb[$];
    logic       src_q[$];
    // Per-cycle expectation: {busy, data_req, enable, encoder_bit, err_inj[1:0]}
    logic [5:0] exp_vec [N];
    logic       enc_log [N];
    logic       flip_log[N];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int last_errs;
    int last_injs;
    bit mon_on   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ix(input int c);
        return c % N;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
    endtask

    // Payload source: answers data_req_o within the same cycle
    initial begin
        data_i = 1'b0;
        forever begin
            @(negedge clk);
            if (data_req_o) data_i = (src_q.size() > 0) ? src_q.pop_front() : 1'b0;
        end
    end

    // Decoder model: ideal DEC_LAT-cycle delay of the encoder input, with
    // optional scheduled flips
    initial begin
        decoder_i = 1'b0;
        forever begin
            @(negedge clk);
            enc_log[ix(cyc)] = encoder_i_o;
            if (cyc >= DEC_LAT) begin
                decoder_i = enc_log[ix(cyc - DEC_LAT)] ^ flip_log[ix(cyc - DEC_LAT)];
                flip_log[ix(cyc - DEC_LAT)] = 1'b0;
            end
        end
    end

    // Monitor: per-cycle output check plus scoreboard pop on done_o
    initial begin
        frame_exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                act = {busy_o, data_req_o, enable_encoder_o, encoder_i_o, err_inj_o};
                chk("cycle_outputs", act, exp_vec[ix(cyc)]);
                exp_vec[ix(cyc)] = '0;
                if (done_o) begin
                    if (sb.size() == 0) begin
                        chk("done_unexpected", done_o, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("bit_err_ct", bit_err_ct_o, e.errs);
                        chk("inj_ct", inj_ct_o, e.injs);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                    chk("done_missing", done_o, 1);
                    e = sb.pop_front();
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    // Issue one frame and model it; called at a negedge with the DUT idle.
    // glitch_at / abort_at are offsets (cycles after the start cycle) at which
    // a stray start or a reset is applied; -1 disables them.
    task automatic run_frame(input int len, input int per, input logic [511:0] fmask,
                             input int glitch_at, input int abort_at);
        int s, d, errs, injs;
        logic [511:0] pb;
        s = cyc + 1;
        d = s + len + TAIL + DEC_LAT + 2;
        errs = 0;
        for (int k = 0; k < len; k++) if (fmask[k]) errs++;
        if (errs > SAT) errs = SAT;
        injs = (per == 0) ? 0 : (len + TAIL) / per;
        if (injs > SAT) injs = SAT;
        pb = '0;
        for (int k = 0; k < len; k++) begin
            pb[k] = 1'($urandom);
            src_q.push_back(pb[k]);
        end
        for (int c = s; c <= d; c++) exp_vec[ix(c)][5] = 1'b1;
        for (int c = s; c < s + len; c++) exp_vec[ix(c)][4] = 1'b1;
        for (int j = 1; j <= len + TAIL; j++) begin
            exp_vec[ix(s + j)][3] = 1'b1;
            exp_vec[ix(s + j)][2] = (j <= len) ? pb[j - 1] : 1'b0;
            flip_log[ix(s + j)]   = fmask[j - 1];
            if (per != 0 && (j % per) == 0) exp_vec[ix(s + j + 1)][1:0] = 2'b10;
        end
        sb.push_back('{d, errs, injs});
        last_errs    = errs;
        last_injs    = injs;
        start_i      = 1'b1;
        frame_len_i  = FRAME_W'(len);
        err_period_i = ERR_W'(per);
        @(negedge clk);
        for (int i = 0; i <= d - s; i++) begin
            if (i == abort_at) begin
                start_i = 1'b0;
                rst     = 1'b1;
                sb.delete();
                src_q.delete();
                for (int c = cyc + 1; c < cyc + 600; c++) begin
                    exp_vec[ix(c)]  = '0;
                    flip_log[ix(c)] = 1'b0;
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start_i = (i == glitch_at);
            if (i == glitch_at) begin
                frame_len_i  = FRAME_W'(len + 7);
                err_period_i = ERR_W'(per + 1);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic check_hold();
        chk("hold_bit_err_ct", bit_err_ct_o, last_errs);
        chk("hold_inj_ct", inj_ct_o, last_injs);
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        logic [511:0] m;
        int len, per;
        for (int c = 0; c < N; c++) begin
            exp_vec[c]  = '0;
            enc_log[c]  = 1'b0;
            flip_log[c] = 1'b0;
        end
        rst          = 1'b1;
        start_i      = 1'b0;
        frame_len_i  = '0;
        err_period_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_enable", enable_encoder_o, 0);
        chk("reset_encoder", encoder_i_o, 0);
        chk("reset_err_inj", err_inj_o, 0);
        chk("reset_data_req", data_req_o, 0);
        chk("reset_bit_err_ct", bit_err_ct_o, 0);
        chk("reset_inj_ct", inj_ct_o, 0);
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // Clean frame, injection off
        m = '0;
        run_frame(8, 0, m, -1, -1);
        check_hold();
        // Periodic injection: 18 symbols, period 4
        run_frame(16, 4, m, -1, -1);
        check_hold();
        // One decoded payload bit flipped
        m = '0; m[3] = 1'b1;
        run_frame(8, 0, m, -1, -1);
        check_hold();
        // Flip on a tail position is not compared
        m = '0; m[8] = 1'b1;
        run_frame(8, 0, m, -1, -1);
        check_hold();
        // Empty payload
        m = '0;
        run_frame(0, 0, m, -1, -1);
        check_hold();
        // Stray start in the middle of SEND
        run_frame(12, 3, m, 3, -1);
        check_hold();
        // Reset while in TAIL, then a clean short frame
        run_frame(6, 2, m, -1, 6);
        chk("abort_busy", busy_o, 0);
        chk("abort_enable", enable_encoder_o, 0);
        chk("abort_bit_err_ct", bit_err_ct_o, 0);
        repeat (20) @(negedge clk);
        run_frame(4, 0, m, -1, -1);
        check_hold();
        // Saturation: 257 injections and 255 flipped payload bits
        m = '0;
        for (int k = 0; k < 257; k++) m[k] = 1'b1;
        run_frame(255, 1, m, -1, -1);
        check_hold();
        // Randomised frames
        for (int f = 0; f < 20; f++) begin
            len = int'($urandom_range(0, 40));
            per = int'($urandom_range(0, 7));
            m = '0;
            for (int k = 0; k < len + TAIL; k++) m[k] = ($urandom_range(0, 5) == 0);
            run_frame(len, per, m, -1, -1);
            check_hold();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
